// File: rtl/csr_exec_unit.sv
// csr_exec_unit: multi-cycle atomic read-modify-write unit for the machine-mode CSR file.
// Defining CSR_COUNTERS_EN adds 64-bit mcycle/minstret plus their read-only cycle/instret shadows.
module csr_exec_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic            csr_read_enable_i,
   input  logic            csr_write_enable_i,
   input  logic [1:0]      csr_write_func_i,
   input  logic            csr_input_sel_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] rs1_value_i,
   input  logic [4:0]      uimm_i,
   input  logic            instret_inc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_rdata_o,
   output logic            out_illegal_o
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

   localparam logic [1:0] FUNC_NONE = 2'b00;
   localparam logic [1:0] FUNC_RW   = 2'b01;
   localparam logic [1:0] FUNC_RS   = 2'b10;
   localparam logic [1:0] FUNC_RC   = 2'b11;

   localparam logic [XLEN-1:0] MSTATUS_WMASK = {{(XLEN-8){1'b0}}, 8'h88};
   localparam logic [XLEN-1:0] ALIGN4_MASK   = {{(XLEN-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_READ   = 2'b01,
      ST_MODIFY = 2'b10,
      ST_RESP   = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              accept_s, lookup_s, modify_s, release_s, wr_commit_s;
   logic              in_ready_q;
   logic              req_re_q, req_we_q;
   logic [1:0]        req_func_q;
   logic [11:0]       req_addr_q;
   logic [XLEN-1:0]   req_src_q;
   logic [XLEN-1:0]   old_q;
   logic              ill_q;
   logic              out_valid_q, out_illegal_q;
   logic [XLEN-1:0]   out_rdata_q;
   logic [XLEN-1:0]   rd_val_s, new_val_s;
   logic              rd_hit_s, lookup_ill_s;
   logic [XLEN-1:0]   mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
`ifdef CSR_COUNTERS_EN
   logic [63:0]       mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
   logic              unused_instret_s;
   assign unused_instret_s = instret_inc_i;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid_i) state_d = ST_READ; else state_d = ST_IDLE;
         ST_READ:   state_d = ST_MODIFY;
         ST_MODIFY: state_d = ST_RESP;
         ST_RESP:   if (out_ready_i) state_d = ST_IDLE; else state_d = ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Per-state control strobes
   always_comb begin
      accept_s  = 1'b0;
      lookup_s  = 1'b0;
      modify_s  = 1'b0;
      release_s = 1'b0;
      case (state_q)
         ST_IDLE:   accept_s  = in_valid_i;
         ST_READ:   lookup_s  = 1'b1;
         ST_MODIFY: modify_s  = 1'b1;
         ST_RESP:   release_s = out_ready_i;
         default:   accept_s  = 1'b0;
      endcase
   end

   // NONE requests never write and report neither data nor an illegal access
   assign wr_commit_s = modify_s && req_we_q && !ill_q && (req_func_q != FUNC_NONE);

   // Ready flag tracks whether the FSM will sit in IDLE next cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) in_ready_q <= 1'b1;
      else       in_ready_q <= (state_d == ST_IDLE);
   end

   // Request capture at accept
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_re_q   <= 1'b0;
         req_we_q   <= 1'b0;
         req_func_q <= FUNC_NONE;
         req_addr_q <= 12'h000;
         req_src_q  <= {XLEN{1'b0}};
      end else if (accept_s) begin
         req_re_q   <= csr_read_enable_i;
         req_we_q   <= csr_write_enable_i;
         req_func_q <= csr_write_func_i;
         req_addr_q <= csr_addr_i;
         req_src_q  <= csr_input_sel_i ? {{(XLEN-5){1'b0}}, uimm_i} : rs1_value_i;
      end
   end

   // CSR address decode and read mux
   always_comb begin
      rd_val_s = {XLEN{1'b0}};
      rd_hit_s = 1'b0;
      case (req_addr_q)
         ADDR_MSTATUS:  begin rd_val_s = mstatus_q;  rd_hit_s = 1'b1; end
         ADDR_MTVEC:    begin rd_val_s = mtvec_q;    rd_hit_s = 1'b1; end
         ADDR_MSCRATCH: begin rd_val_s = mscratch_q; rd_hit_s = 1'b1; end
         ADDR_MEPC:     begin rd_val_s = mepc_q;     rd_hit_s = 1'b1; end
         ADDR_MCAUSE:   begin rd_val_s = mcause_q;   rd_hit_s = 1'b1; end
`ifdef CSR_COUNTERS_EN
         ADDR_MCYCLE, ADDR_CYCLE:       begin rd_val_s = mcycle_q[31:0];    rd_hit_s = 1'b1; end
         ADDR_MCYCLEH, ADDR_CYCLEH:     begin rd_val_s = mcycle_q[63:32];   rd_hit_s = 1'b1; end
         ADDR_MINSTRET, ADDR_INSTRET:   begin rd_val_s = minstret_q[31:0];  rd_hit_s = 1'b1; end
         ADDR_MINSTRETH, ADDR_INSTRETH: begin rd_val_s = minstret_q[63:32]; rd_hit_s = 1'b1; end
`endif
         default:       begin rd_val_s = {XLEN{1'b0}}; rd_hit_s = 1'b0; end
      endcase
   end

   assign lookup_ill_s = (req_func_q != FUNC_NONE) &&
                         (!rd_hit_s || (req_we_q && (req_addr_q[11:10] == 2'b11)));

   // Old value and legality latched in READ
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         old_q <= {XLEN{1'b0}};
         ill_q <= 1'b0;
      end else if (lookup_s) begin
         old_q <= rd_val_s;
         ill_q <= lookup_ill_s;
      end
   end

   // Read-modify-write operator
   always_comb begin
      new_val_s = old_q;
      case (req_func_q)
         FUNC_RW: new_val_s = req_src_q;
         FUNC_RS: new_val_s = old_q | req_src_q;
         FUNC_RC: new_val_s = old_q & ~req_src_q;
         default: new_val_s = old_q;
      endcase
   end

   // Response registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q   <= 1'b0;
         out_rdata_q   <= {XLEN{1'b0}};
         out_illegal_q <= 1'b0;
      end else if (modify_s) begin
         out_valid_q   <= 1'b1;
         out_rdata_q   <= (req_re_q && !ill_q && (req_func_q != FUNC_NONE)) ? old_q : {XLEN{1'b0}};
         out_illegal_q <= ill_q;
      end else if (release_s) begin
         out_valid_q   <= 1'b0;
      end
   end

   // CSR file with WARL masking applied on write
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mstatus_q  <= {XLEN{1'b0}};
         mtvec_q    <= MTVEC_RESET & ALIGN4_MASK;
         mscratch_q <= {XLEN{1'b0}};
         mepc_q     <= {XLEN{1'b0}};
         mcause_q   <= {XLEN{1'b0}};
      end else if (wr_commit_s) begin
         case (req_addr_q)
            ADDR_MSTATUS:  mstatus_q  <= new_val_s & MSTATUS_WMASK;
            ADDR_MTVEC:    mtvec_q    <= new_val_s & ALIGN4_MASK;
            ADDR_MSCRATCH: mscratch_q <= new_val_s;
            ADDR_MEPC:     mepc_q     <= new_val_s & ALIGN4_MASK;
            ADDR_MCAUSE:   mcause_q   <= new_val_s;
            default:       mscratch_q <= mscratch_q;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   // A committed write to either half replaces the whole counter's increment this cycle
   always_comb begin
      if (wr_commit_s && (req_addr_q == ADDR_MCYCLE)) begin
         mcycle_d = {mcycle_q[63:32], new_val_s[31:0]};
      end else if (wr_commit_s && (req_addr_q == ADDR_MCYCLEH)) begin
         mcycle_d = {new_val_s[31:0], mcycle_q[31:0]};
      end else begin
         mcycle_d = mcycle_q + 64'd1;
      end
      if (wr_commit_s && (req_addr_q == ADDR_MINSTRET)) begin
         minstret_d = {minstret_q[63:32], new_val_s[31:0]};
      end else if (wr_commit_s && (req_addr_q == ADDR_MINSTRETH)) begin
         minstret_d = {new_val_s[31:0], minstret_q[31:0]};
      end else if (instret_inc_i) begin
         minstret_d = minstret_q + 64'd1;
      end else begin
         minstret_d = minstret_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcycle_q   <= 64'd0;
         minstret_q <= 64'd0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`endif

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign out_rdata_o   = out_rdata_q;
   assign out_illegal_o = out_illegal_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: directed requests push expected responses, a monitor pops and compares.
module tb_csr_exec_unit;

   localparam logic [1:0] F_NONE = 2'b00;
   localparam logic [1:0] F_RW   = 2'b01;
   localparam logic [1:0] F_RS   = 2'b10;
   localparam logic [1:0] F_RC   = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        re = 1'b0, we = 1'b0, sel = 1'b0;
   logic [1:0]  func = 2'b00;
   logic [11:0] addr = 12'h000;
   logic [31:0] rs1v = 32'h0;
   logic [4:0]  imm = 5'h0;
   logic        instret_inc = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rdata;
   logic        out_illegal;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ill;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;

   csr_exec_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .csr_read_enable_i(re), .csr_write_enable_i(we), .csr_write_func_i(func),
      .csr_input_sel_i(sel), .csr_addr_i(addr), .rs1_value_i(rs1v), .uimm_i(imm),
      .instret_inc_i(instret_inc), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_rdata_o(out_rdata), .out_illegal_o(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every completed handshake is compared against the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_response actual=%h/%b expected=none", out_rdata, out_illegal);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", out_rdata, e.rdata);
            chk("resp_illegal", {31'h0, out_illegal}, {31'h0, e.ill});
         end
      end
   end

   task automatic issue(input logic r, input logic w, input logic [1:0] f, input logic s,
                        input logic [11:0] a, input logic [31:0] v, input logic [4:0] u,
                        input logic [31:0] exp_rd, input logic exp_ill, input bit push);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout actual=in_ready0 expected=in_ready1");
      end
      if (push) begin
         e.rdata = exp_rd;
         e.ill   = exp_ill;
         exp_q.push_back(e);
      end
      re = r; we = w; func = f; sel = s; addr = a; rs1v = v; imm = u;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp_rd, input logic exp_ill);
      issue(1'b1, 1'b0, F_RS, 1'b1, a, 32'h0, 5'h00, exp_rd, exp_ill, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !in_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || !in_ready) begin
         failures++;
         $display("FAIL drain_timeout actual=pending%0d expected=pending0", exp_q.size());
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
      chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
      chk({tag, "_out_rdata"}, out_rdata, 32'h0);
      chk({tag, "_out_illegal"}, {31'h0, out_illegal}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");

      // CSRRW mscratch with latency check: valid appears after the second edge past accept
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'h00, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      chk("lat_read_cycle", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      chk("lat_modify_cycle", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      chk("lat_resp_cycle", {31'h0, out_valid}, 32'h1);
      drain();
      rd(12'h340, 32'hDEAD_BEEF, 1'b0);

      // mstatus WARL: only MIE/MPIE stick
      issue(1'b1, 1'b1, F_RS, 1'b0, 12'h300, 32'hFFFF_FFFF, 5'h00, 32'h0, 1'b0, 1'b1);
      rd(12'h300, 32'h0000_0088, 1'b0);

      // mtvec clear of low bits and alignment masking
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'h305, 32'h0000_1000, 5'h00, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 1'b1, F_RC, 1'b1, 12'h305, 32'h0, 5'h1F, 32'h0000_1000, 1'b0, 1'b1);
      rd(12'h305, 32'h0000_1000, 1'b0);
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'h305, 32'h0000_2003, 5'h00, 32'h0000_1000, 1'b0, 1'b1);
      rd(12'h305, 32'h0000_2000, 1'b0);

      // Illegal: write to read-only space, unimplemented read
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'hC00, 32'h1234_5678, 5'h00, 32'h0, 1'b1, 1'b1);
      rd(12'h7C0, 32'h0, 1'b1);

      // read_enable=0 still writes; NONE has no effect and no illegal flag
      issue(1'b0, 1'b1, F_RW, 1'b0, 12'h340, 32'h1111_2222, 5'h00, 32'h0, 1'b0, 1'b1);
      rd(12'h340, 32'h1111_2222, 1'b0);
      issue(1'b1, 1'b1, F_NONE, 1'b0, 12'h7C0, 32'hFFFF_FFFF, 5'h00, 32'h0, 1'b0, 1'b1);

      // mepc alignment, mcause full width
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'h341, 32'hFFFF_FFFF, 5'h00, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 1'b1, F_RC, 1'b1, 12'h341, 32'h0, 5'h00, 32'hFFFF_FFFC, 1'b0, 1'b1);
      rd(12'h341, 32'hFFFF_FFFC, 1'b0);
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'h342, 32'h8000_000B, 5'h00, 32'h0, 1'b0, 1'b1);
      rd(12'h342, 32'h8000_000B, 1'b0);
      drain();

      // Backpressure: response held stable, second request refused
      out_ready = 1'b0;
      rd(12'h340, 32'h1111_2222, 1'b0);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      re = 1'b1; we = 1'b1; func = F_RW; sel = 1'b0; addr = 12'h340; rs1v = 32'h5555_5555;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
         chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
         chk("hold_out_rdata", out_rdata, 32'h1111_2222);
         chk("hold_out_illegal", {31'h0, out_illegal}, 32'h0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", {31'h0, in_ready}, 32'h1);
      chk("release_out_valid", {31'h0, out_valid}, 32'h0);
      drain();
      rd(12'h340, 32'h1111_2222, 1'b0);
      drain();

      // Reset during MODIFY aborts the write and clears everything
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'h340, 32'hAAAA_5555, 5'h00, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midop_reset");
      rd(12'h340, 32'h0, 1'b0);
      rd(12'h300, 32'h0, 1'b0);
      rd(12'h305, 32'h0, 1'b0);
      drain();

`ifdef CSR_COUNTERS_EN
      // mcycle carry from lo to hi
      issue(1'b0, 1'b1, F_RW, 1'b0, 12'hB80, 32'h0, 5'h00, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 1'b1, F_RW, 1'b0, 12'hB00, 32'hFFFF_FFFF, 5'h00, 32'h0, 1'b0, 1'b1);
      rd(12'hB80, 32'h0000_0001, 1'b0);
      rd(12'hC80, 32'h0000_0001, 1'b0);
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'hC02, 32'h1, 5'h00, 32'h0, 1'b1, 1'b1);
      drain();
      // minstret counts retire pulses
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) instret_inc = 1'b1;
         @(negedge clk) instret_inc = 1'b0;
      end
      rd(12'hB02, 32'h0000_0003, 1'b0);
      rd(12'hC02, 32'h0000_0003, 1'b0);
      rd(12'hC82, 32'h0000_0000, 1'b0);
      drain();
      // Reset during a counter write leaves it zero
      issue(1'b1, 1'b1, F_RW, 1'b0, 12'hB02, 32'h0000_0055, 5'h00, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      rd(12'hB02, 32'h0, 1'b0);
      drain();
`else
      rd(12'hB00, 32'h0, 1'b1);
      rd(12'hC02, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk) instret_inc = 1'b1;
         @(negedge clk) instret_inc = 1'b0;
      end
      rd(12'hB02, 32'h0, 1'b1);
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
